mux_tree_pipe: RTL and testbench
================================

MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width of each channel, >=1.
REQ-002 Parameter SEL_BITS, default 2: select width, >=1; channel count N = 2**SEL_BITS.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port en, input, 1: pipeline advance enable; 0 = hold all state.
REQ-007 Port mode, input, 1: 0 = external select, 1 = auto-scan.
REQ-008 Port in_valid, input, 1: sample qualifier for the current data_in/select.
REQ-009 Port data_in, input, N*WIDTH: channel i occupies data_in[i*WIDTH +: WIDTH].
REQ-010 Port sel, input, SEL_BITS: channel index used when mode=0.
REQ-011 Port scan_clr, input, 1: synchronous clear of the scan pointer.
REQ-012 Port data_out, output, WIDTH: selected channel data.
REQ-013 Port out_valid, output, 1: data_out/out_chan qualifier.
REQ-014 Port out_chan, output, SEL_BITS: channel index that produced data_out.
REQ-015 Port scan_ptr, output, SEL_BITS: current auto-scan pointer.

Function
REQ-016 Effective select s SHALL be sel when mode=0 and scan_ptr when mode=1, sampled in the accepting cycle.
REQ-017 A sample SHALL be accepted on a rising clk edge with en=1; in_valid=0 samples propagate as bubbles (valid=0).
REQ-018 The mux SHALL be a binary tree of SEL_BITS levels of 2:1 muxes; level k (k=0 first) SHALL use s[k], 0 picking the lower-indexed input.
REQ-019 Each tree level SHALL be followed by a register holding partial data, valid and s.
REQ-020 Latency SHALL be exactly SEL_BITS en=1 edges from acceptance to out_valid/data_out/out_chan.
REQ-021 Throughput SHALL be one sample per en=1 cycle; no backpressure beyond en.
REQ-022 With en=0, all pipeline registers, outputs and scan_ptr SHALL hold; no sample is lost or duplicated.
REQ-023 data_out SHALL equal data_in[s*WIDTH +: WIDTH] of the accepted cycle; out_chan SHALL equal s.
REQ-024 scan_ptr SHALL increment by 1 on en=1 & mode=1 & in_valid=1, wrapping N-1 -> 0.
REQ-025 scan_clr=1 with en=1 SHALL load scan_ptr=0, overriding increment; the sample accepted that cycle uses the pre-clear scan_ptr.
REQ-026 scan_ptr SHALL hold when mode=0 and resume from its held value when mode returns to 1.
REQ-027 A mode change SHALL affect only samples accepted after it; in-flight samples complete unchanged.
REQ-028 data_out and out_chan while out_valid=0 SHALL still reflect the bubble path; consumers rely only on out_valid.

Reset
REQ-029 rst=1 SHALL immediately clear all pipeline registers: out_valid=0, data_out=0, out_chan=0, scan_ptr=0.
REQ-030 Reset mid-operation SHALL discard all in-flight samples; the first post-release sample emerges SEL_BITS en=1 edges after acceptance.
REQ-031 rst SHALL override en and scan_clr.

Verification (WIDTH=8, SEL_BITS=2, data_in={8'h44,8'h33,8'h22,8'h11}, so ch0=8'h11)
REQ-032 mode=0, sel=2, in_valid pulse, en=1 -> two edges later out_valid=1, data_out=8'h33, out_chan=2, for one cycle.
REQ-033 mode=1, six consecutive in_valid cycles -> data_out 11,22,33,44,11,22; out_chan 0,1,2,3,0,1; scan_ptr ends at 2.
REQ-034 mode=0, sel=1 accepted, en=0 for 3 cycles after the first edge -> outputs frozen; 8'h22 appears on the next en=1 edge, exactly once.
REQ-035 mode=1, scan_ptr=3, scan_clr=1 with in_valid=1 -> that sample outputs 8'h44 with out_chan=3; scan_ptr=0 next cycle; following sample outputs 8'h11.
REQ-036 Two samples in flight, rst pulsed asynchronously mid-cycle -> out_valid=0, data_out=0, scan_ptr=0 without a clock edge; no stale sample after release.
REQ-037 mode=0, sel=3,0,1 on back-to-back cycles -> data_out 44,11,22 on consecutive cycles starting at latency 2, out_valid held high.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined binary mux tree with external or auto-scan channel select
module mux_tree_pipe #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               mode,
  input  logic                               in_valid,
  input  logic [(1<<SEL_BITS)*WIDTH-1:0]     data_in,
  input  logic [SEL_BITS-1:0]                sel,
  input  logic                               scan_clr,
  output logic [WIDTH-1:0]                   data_out,
  output logic                               out_valid,
  output logic [SEL_BITS-1:0]                out_chan,
  output logic [SEL_BITS-1:0]                scan_ptr
);

  localparam int N = 1 << SEL_BITS;

  logic [SEL_BITS-1:0] s_eff;

  assign s_eff = mode ? scan_ptr : sel;

  // Clear wins over increment; the sample taken this cycle already used the old pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr <= '0;
    end else if (en) begin
      if (scan_clr) begin
        scan_ptr <= '0;
      end else if (mode && in_valid) begin
        scan_ptr <= scan_ptr + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < SEL_BITS; k++) begin : g_lvl
    localparam int IN_N  = N >> k;
    localparam int OUT_N = N >> (k + 1);

    logic [IN_N*WIDTH-1:0]  d_in;
    logic [SEL_BITS-1:0]    s_in;
    logic                   v_in;
    logic [OUT_N*WIDTH-1:0] d_mux;
    logic [OUT_N*WIDTH-1:0] d_q;
    logic [SEL_BITS-1:0]    s_q;
    logic                   v_q;

    if (k == 0) begin : g_head
      assign d_in = data_in;
      assign s_in = s_eff;
      assign v_in = in_valid;
    end else begin : g_body
      assign d_in = g_lvl[k-1].d_q;
      assign s_in = g_lvl[k-1].s_q;
      assign v_in = g_lvl[k-1].v_q;
    end

    // Level k resolves select bit k; bubbles travel through the same path.
    always_comb begin
      d_mux = '0;
      for (int j = 0; j < OUT_N; j++) begin
        d_mux[j*WIDTH +: WIDTH] = s_in[k] ? d_in[(2*j+1)*WIDTH +: WIDTH]
                                          : d_in[(2*j)*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_q <= '0;
        s_q <= '0;
        v_q <= 1'b0;
      end else if (en) begin
        d_q <= d_mux;
        s_q <= s_in;
        v_q <= v_in;
      end
    end
  end

  assign data_out  = g_lvl[SEL_BITS-1].d_q;
  assign out_chan  = g_lvl[SEL_BITS-1].s_q;
  assign out_valid = g_lvl[SEL_BITS-1].v_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - directed self-checking bench for mux_tree_pipe
module tb_mux_tree_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic        in_valid;
  logic [31:0] data_in;
  logic [1:0]  sel;
  logic        scan_clr;
  logic [7:0]  data_out;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic [1:0]  scan_ptr;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] ch_val [0:3];

  mux_tree_pipe #(.WIDTH(8), .SEL_BITS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .data_in(data_in), .sel(sel), .scan_clr(scan_clr),
    .data_out(data_out), .out_valid(out_valid), .out_chan(out_chan), .scan_ptr(scan_ptr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    check_eq({tag, " valid"}, 32'(out_valid), 32'(v));
    check_eq({tag, " data"}, 32'(data_out), 32'(d));
    check_eq({tag, " chan"}, 32'(out_chan), 32'(c));
  endtask

  initial begin
    ch_val[0] = 8'h11; ch_val[1] = 8'h22; ch_val[2] = 8'h33; ch_val[3] = 8'h44;
    rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11}; sel = 2'd0; scan_clr = 1'b0;
    #2;
    check_out("reset", 1'b0, 8'h00, 2'd0);
    check_eq("reset scan_ptr", 32'(scan_ptr), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single sample, external select
    sel = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("sel2 latency1", 32'(out_valid), 32'd0);
    tick();
    check_out("sel2", 1'b1, 8'h33, 2'd2);
    tick();
    check_eq("sel2 one cycle", 32'(out_valid), 32'd0);

    // auto-scan, six samples
    mode = 1'b1;
    for (int t = 0; t < 8; t++) begin
      in_valid = (t < 6);
      tick();
      if (t >= 1 && t <= 6)
        check_out($sformatf("scan%0d", t - 1), 1'b1, ch_val[(t-1)%4], 2'((t-1)%4));
    end
    check_eq("scan end ptr", 32'(scan_ptr), 32'd2);

    // en stall
    mode = 1'b0; sel = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; en = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check_eq($sformatf("stall%0d valid", t), 32'(out_valid), 32'd0);
    end
    check_eq("stall scan_ptr hold", 32'(scan_ptr), 32'd2);
    en = 1'b1;
    tick();
    check_out("stall release", 1'b1, 8'h22, 2'd1);
    tick();
    check_eq("stall once", 32'(out_valid), 32'd0);

    // scan clear at pointer 3
    mode = 1'b1; in_valid = 1'b1;
    tick();
    check_eq("ptr at 3", 32'(scan_ptr), 32'd3);
    scan_clr = 1'b1;
    tick();
    check_eq("clr ptr", 32'(scan_ptr), 32'd0);
    check_out("pre-clr ch2", 1'b1, 8'h33, 2'd2);
    scan_clr = 1'b0;
    tick();
    check_out("clr sample", 1'b1, 8'h44, 2'd3);
    in_valid = 1'b0;
    tick();
    check_out("post clr", 1'b1, 8'h11, 2'd0);
    tick();

    // async reset with two in flight
    mode = 1'b0; in_valid = 1'b1; sel = 2'd3;
    tick();
    sel = 2'd0;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_out("async rst", 1'b0, 8'h00, 2'd0);
    check_eq("async rst ptr", 32'(scan_ptr), 32'd0);
    #1 rst = 1'b0;
    tick();
    check_eq("no stale 1", 32'(out_valid), 32'd0);
    tick();
    check_eq("no stale 2", 32'(out_valid), 32'd0);
    sel = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_out("post rst", 1'b1, 8'h33, 2'd2);

    // back-to-back external selects
    in_valid = 1'b1; sel = 2'd3;
    tick();
    sel = 2'd0;
    tick();
    check_out("b2b 0", 1'b1, 8'h44, 2'd3);
    sel = 2'd1;
    tick();
    check_out("b2b 1", 1'b1, 8'h11, 2'd0);
    in_valid = 1'b0;
    tick();
    check_out("b2b 2", 1'b1, 8'h22, 2'd1);
    tick();
    check_eq("b2b drain", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
